// File: rtl/ps2_host_fifo_if.sv
// Bus-side bundle of the PS/2 host: TX strobe/busy, RX FIFO head/pop,
// sticky error flags and interrupt.
interface ps2_host_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    tx_data;
  logic          tx_we;
  logic          tx_busy;
  logic [7:0]    rx_data;
  logic          rx_re;
  logic          rx_avail;
  logic [CW-1:0] rx_count;
  logic [4:0]    err_flags;
  logic          err_clr;
  logic          irq;

  modport master (
    output tx_data, tx_we, rx_re, err_clr,
    input  tx_busy, rx_data, rx_avail,
    input  rx_count, err_flags, irq
  );

  modport slave (
    input  tx_data, tx_we, rx_re, err_clr,
    output tx_busy, rx_data, rx_avail,
    output rx_count, err_flags, irq
  );
endinterface

// File: rtl/ps2_host_fifo.sv
// PS/2 host controller: filtered device clock, RX frames into a
// show-ahead FIFO, host-to-device transmit with ACK, sticky errors.
module ps2_host_fifo #(
  parameter int unsigned clk_freq   = 50000000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  inout  wire  ps2_clk,
  inout  wire  ps2_data,
  ps2_host_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [31:0] TO_CYC =
    32'(clk_freq / 1000000 * TIMEOUT_US);
  localparam logic [31:0] INH_CYC = 32'(clk_freq / 10000);
  localparam logic [31:0] CAP_CYC = 32'(clk_freq / 1000 * 15);

  typedef enum logic [2:0] {
    IDLE, RX, TX_INH, TX_RTS, TX_BITS, TX_ACK
  } state_t;

  state_t        state_q, state_d;
  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    sh_q, sh_d;
  logic [9:0]    txsh_q, txsh_d;
  logic [31:0]   to_q, to_d;
  logic [31:0]   cap_q, cap_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic [4:0]    err_q, err_d;
  logic          irq_q, irq_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       fall, push, abort, pop, full, wr_en;
  logic [4:0] err_set;

  always_comb begin
    clk_s1_d = ps2_clk;
    clk_s2_d = clk_s1_q;
    dat_s1_d = ps2_data;
    dat_s2_d = dat_s1_q;
    filt_d   = filt_q;
    fcnt_d   = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else fcnt_d = fcnt_q + FW'(1);
    end
    fall = filt_q & ~filt_d;

    state_d  = state_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    txsh_d   = txsh_q;
    to_d     = to_q;
    cap_d    = cap_q;
    ack_d    = ack_q;
    busy_d   = busy_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    err_set  = '0;
    push     = 1'b0;
    abort    = 1'b0;

    unique case (state_q)
      IDLE: if (fall) begin
        if (!dat_s2_q) begin
          state_d = RX;
          bit_d   = '0;
          to_d    = TO_CYC;
        end else err_set[0] = 1'b1;
      end
      RX: if (fall) begin
        to_d  = TO_CYC;
        sh_d  = {dat_s2_q, sh_q[9:1]};
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'd9) begin
          state_d = IDLE;
          if (!dat_s2_q) err_set[0] = 1'b1;
          else if (!(^sh_d[8:0])) err_set[1] = 1'b1;
          else push = 1'b1;
        end
      end else if (to_q == '0) abort = 1'b1;
      else to_d = to_q - 32'd1;
      TX_INH: if (to_q == '0) begin
        state_d  = TX_RTS;
        dat_oe_d = 1'b1;
      end else to_d = to_q - 32'd1;
      TX_RTS: begin
        state_d  = TX_BITS;
        clk_oe_d = 1'b0;
        bit_d    = '0;
        cap_d    = CAP_CYC;
      end
      TX_BITS: if (cap_q == '0) abort = 1'b1;
      else begin
        cap_d = cap_q - 32'd1;
        if (fall) begin
          dat_oe_d = ~txsh_q[bit_q];
          bit_d    = bit_q + 4'd1;
          to_d     = TO_CYC;
          if (bit_q == 4'd9) state_d = TX_ACK;
        end else if (bit_q != '0) begin
          // gap timer only runs once the device has started clocking
          if (to_q == '0) abort = 1'b1;
          else to_d = to_q - 32'd1;
        end
      end
      TX_ACK: if (cap_q == '0) abort = 1'b1;
      else begin
        cap_d = cap_q - 32'd1;
        if (ack_q) begin
          if (filt_q) begin
            state_d = IDLE;
            ack_d   = 1'b0;
            busy_d  = 1'b0;
          end
        end else if (fall) begin
          ack_d      = 1'b1;
          err_set[4] = dat_s2_q;
        end else if (to_q == '0) abort = 1'b1;
        else to_d = to_q - 32'd1;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = IDLE;
      clk_oe_d   = 1'b0;
      dat_oe_d   = 1'b0;
      busy_d     = 1'b0;
      ack_d      = 1'b0;
      err_set[3] = 1'b1;
    end

    // a new transmit pre-empts any partial receive without flagging it
    if (bus.tx_we && !busy_q) begin
      state_d  = TX_INH;
      busy_d   = 1'b1;
      clk_oe_d = 1'b1;
      dat_oe_d = 1'b0;
      ack_d    = 1'b0;
      to_d     = INH_CYC - 32'd1;
      txsh_d   = {1'b1, ~^bus.tx_data, bus.tx_data};
    end

    pop   = bus.rx_re && (cnt_q != '0);
    full  = cnt_q == CW'(FIFO_DEPTH);
    wr_en = push && (!full || pop);
    if (push && full && !pop) err_set[2] = 1'b1;
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (wr_en) begin
      mem_d[wr_q] = sh_d[7:0];
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    if (wr_en && !pop) cnt_d = cnt_q + CW'(1);
    else if (pop && !wr_en) cnt_d = cnt_q - CW'(1);

    err_d = (bus.err_clr ? 5'b0 : err_q) | err_set;
    irq_d = (cnt_q != '0) | (|err_q);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      txsh_q   <= '0;
      to_q     <= '0;
      cap_q    <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      err_q    <= '0;
      irq_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++)
        mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      clk_s1_q <= clk_s1_d;
      clk_s2_q <= clk_s2_d;
      dat_s1_q <= dat_s1_d;
      dat_s2_q <= dat_s2_d;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      txsh_q   <= txsh_d;
      to_q     <= to_d;
      cap_q    <= cap_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

  assign ps2_clk      = clk_oe_q ? 1'b0 : 1'bz;
  assign ps2_data     = dat_oe_q ? 1'b0 : 1'bz;
  assign bus.tx_busy   = busy_q;
  assign bus.rx_data   = mem_q[rd_q];
  assign bus.rx_avail  = cnt_q != '0;
  assign bus.rx_count  = cnt_q;
  assign bus.err_flags = err_q;
  assign bus.irq       = irq_q;
endmodule
